// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - register map, control bits and month-length table for the RTC responder
package rtc_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_CSEC  = 8'h41;
  localparam logic [7:0] ADDR_CMIN  = 8'h42;
  localparam logic [7:0] ADDR_CHOUR = 8'h43;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DONE = 1;

  // BCD days per month, December in the top byte down to January in the bottom byte
  localparam logic [95:0] MONTH_DAYS = {8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31,
                                        8'h30, 8'h31, 8'h30, 8'h31, 8'h28, 8'h31};

  function automatic logic [7:0] month_days(input logic [7:0] month);
    int idx;
    idx = 10 * int'(month[7:4]) + int'(month[3:0]);
    if (idx >= 1 && idx <= 12) return MONTH_DAYS[(idx-1)*8 +: 8];
    return 8'h31;
  endfunction

endpackage

// File: rtl/bcd_pair.sv
// rtl/bcd_pair.sv - two-digit BCD step up or down with programmable wrap limit and carry/borrow
module bcd_pair (
  input  logic [7:0] value,
  input  logic [7:0] limit,
  input  logic [7:0] base,
  input  logic       step,
  input  logic       down,
  output logic [7:0] next,
  output logic       carry
);

  always_comb begin
    next  = value;
    carry = 1'b0;
    if (step) begin
      if (!down) begin
        // Anything at or beyond the limit wraps, so garbage written by software self-heals
        if (value >= limit) begin
          next  = base;
          carry = 1'b1;
        end else if (value[3:0] >= 4'd9) begin
          next = {value[7:4] + 4'd1, 4'd0};
        end else begin
          next = value + 8'd1;
        end
      end else begin
        if (value <= base) begin
          next  = limit;
          carry = 1'b1;
        end else if (value[3:0] == 4'd0) begin
          next = {value[7:4] - 4'd1, 4'd9};
        end else begin
          next = value - 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/rtc_responder.sv
// rtl/rtc_responder.sv - RTC with countdown timer behind a multiplexed address/data strobe bus
module rtc_responder #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ChipSelect,
  input  logic       Read,
  input  logic       Write,
  input  logic       AoD,
  inout  wire  [7:0] DATA_ADDRESS,
  output logic       crono_irq
);
  import rtc_pkg::*;

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [3:0] sync [SYNC_STAGES];
  logic       cs_n, rd_n, wr_n, aod;
  logic       rd_q, wr_q, wr_ok, wr_bad;
  logic       wr_rise, rd_fall, commit;
  logic [7:0] wdata, ptr, rdata, read_mux;
  logic       drive;
  logic [CW-1:0] cnt;
  logic       tick, tick_pend, apply;
  logic       en, done;
  logic [7:0] sec, minute, hour, day, month, year, c_sec, c_min, c_hour;
  logic [7:0] n_sec, n_min, n_hour, n_day, n_month, n_year, n_csec, n_cmin, n_chour;
  logic       cy_sec, cy_min, cy_hour, cy_day, cy_month, unused_year_carry;
  logic       cb_sec, cb_min, unused_hour_borrow;
  logic       c_zero, n_zero;

  // Each stage carries {cs_n, rd_n, wr_n, aod}; reset to the idle bus state
  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= 4'b1110;
    end else begin
      sync[0] <= {ChipSelect, Read, Write, AoD};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign {cs_n, rd_n, wr_n, aod} = sync[SYNC_STAGES-1];
  assign wr_rise = wr_n && !wr_q;
  assign rd_fall = !rd_n && rd_q;
  assign commit  = wr_rise && !cs_n && wr_ok && !wr_bad;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      wr_ok  <= 1'b0;
      wr_bad <= 1'b0;
      wdata  <= 8'h00;
      drive  <= 1'b0;
      rdata  <= 8'h00;
    end else begin
      rd_q <= rd_n;
      wr_q <= wr_n;
      if (wr_rise) begin
        wr_ok  <= 1'b0;
        wr_bad <= 1'b0;
      end else if (!wr_n) begin
        if (!rd_n) begin
          wr_bad <= 1'b1;
        end else if (!cs_n) begin
          wr_ok <= 1'b1;
          wdata <= DATA_ADDRESS;
        end
      end
      if (rd_fall && !cs_n && aod && wr_n) begin
        drive <= 1'b1;
        rdata <= read_mux;
      end else if (rd_n || cs_n || !aod || !wr_n) begin
        drive <= 1'b0;
      end
    end
  end

  assign DATA_ADDRESS = drive ? rdata : 8'hzz;
  assign crono_irq    = done;

  always_comb begin
    read_mux = 8'h00;
    case (ptr)
      ADDR_CTRL: begin
        read_mux[CTRL_EN]   = en;
        read_mux[CTRL_DONE] = done;
      end
      ADDR_SEC:   read_mux = sec;
      ADDR_MIN:   read_mux = minute;
      ADDR_HOUR:  read_mux = hour;
      ADDR_DAY:   read_mux = day;
      ADDR_MONTH: read_mux = month;
      ADDR_YEAR:  read_mux = year;
      ADDR_CSEC:  read_mux = c_sec;
      ADDR_CMIN:  read_mux = c_min;
      ADDR_CHOUR: read_mux = c_hour;
      default:    read_mux = 8'h00;
    endcase
  end

  assign tick  = (cnt == CW'(TICKS_PER_SEC - 1));
  assign apply = (tick || tick_pend) && !commit;

  always_ff @(posedge clk) begin
    if (!Reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + CW'(1);
  end

  bcd_pair u_sec   (.value(sec),    .limit(8'h59),            .base(8'h00), .step(apply),    .down(1'b0), .next(n_sec),   .carry(cy_sec));
  bcd_pair u_min   (.value(minute), .limit(8'h59),            .base(8'h00), .step(cy_sec),   .down(1'b0), .next(n_min),   .carry(cy_min));
  bcd_pair u_hour  (.value(hour),   .limit(8'h23),            .base(8'h00), .step(cy_min),   .down(1'b0), .next(n_hour),  .carry(cy_hour));
  bcd_pair u_day   (.value(day),    .limit(month_days(month)), .base(8'h01), .step(cy_hour),  .down(1'b0), .next(n_day),   .carry(cy_day));
  bcd_pair u_month (.value(month),  .limit(8'h12),            .base(8'h01), .step(cy_day),   .down(1'b0), .next(n_month), .carry(cy_month));
  bcd_pair u_year  (.value(year),   .limit(8'h99),            .base(8'h00), .step(cy_month), .down(1'b0), .next(n_year),  .carry(unused_year_carry));

  assign c_zero = ({c_hour, c_min, c_sec} == 24'd0);
  assign n_zero = ({n_chour, n_cmin, n_csec} == 24'd0);

  bcd_pair u_csec  (.value(c_sec),  .limit(8'h59), .base(8'h00), .step(apply && en && !c_zero), .down(1'b1), .next(n_csec),  .carry(cb_sec));
  bcd_pair u_cmin  (.value(c_min),  .limit(8'h59), .base(8'h00), .step(cb_sec),                 .down(1'b1), .next(n_cmin),  .carry(cb_min));
  bcd_pair u_chour (.value(c_hour), .limit(8'h23), .base(8'h00), .step(cb_min),                 .down(1'b1), .next(n_chour), .carry(unused_hour_borrow));

  // A bus commit wins the cycle; a colliding tick is held one cycle and applied after it
  always_ff @(posedge clk) begin
    if (!Reset) begin
      ptr <= 8'h00; en <= 1'b0; done <= 1'b0; tick_pend <= 1'b0;
      sec <= 8'h00; minute <= 8'h00; hour <= 8'h00;
      day <= 8'h01; month <= 8'h01; year <= 8'h00;
      c_sec <= 8'h00; c_min <= 8'h00; c_hour <= 8'h00;
    end else begin
      tick_pend <= commit && (tick || tick_pend);
      if (commit) begin
        if (!aod) begin
          ptr <= wdata;
        end else begin
          case (ptr)
            ADDR_CTRL: begin
              en <= wdata[CTRL_EN];
              if (wdata[CTRL_DONE]) done <= 1'b0;
            end
            ADDR_SEC:   sec    <= wdata;
            ADDR_MIN:   minute <= wdata;
            ADDR_HOUR:  hour   <= wdata;
            ADDR_DAY:   day    <= wdata;
            ADDR_MONTH: month  <= wdata;
            ADDR_YEAR:  year   <= wdata;
            ADDR_CSEC:  c_sec  <= wdata;
            ADDR_CMIN:  c_min  <= wdata;
            ADDR_CHOUR: c_hour <= wdata;
            default: ;
          endcase
        end
      end else if (apply) begin
        sec <= n_sec; minute <= n_min; hour <= n_hour;
        day <= n_day; month <= n_month; year <= n_year;
        if (en) begin
          c_sec <= n_csec; c_min <= n_cmin; c_hour <= n_chour;
          if (c_zero || n_zero) begin
            done <= 1'b1;
            en   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_responder.sv
// tb/tb_rtc_responder.sv - directed bench for rtc_responder bus timing, timekeeping and crono
`timescale 1ns/1ps
module tb_rtc_responder;

  localparam int T    = 300;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, cs, rd, wr, aod, tb_oe, irq;
  logic [7:0] tb_drv;
  tri1  [7:0] bus;
  int         cyc, n_tests, n_fail;

  assign bus = tb_oe ? tb_drv : 8'hzz;
  always #5 clk = ~clk;
  // Edges since reset release; mirrors where the one-second ticks must fall
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  rtc_responder #(.TICKS_PER_SEC(T), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .Reset(rst_n), .ChipSelect(cs), .Read(rd), .Write(wr),
    .AoD(aod), .DATA_ADDRESS(bus), .crono_irq(irq)
  );

  task automatic do_reset();
    @(negedge clk);
    cs = 1; rd = 1; wr = 1; aod = 0; tb_oe = 0; tb_drv = 8'h00; rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic bus_write(input logic phase, input logic [7:0] data);
    aod = phase; tb_drv = data; tb_oe = 1; cs = 0; wr = 0;
    repeat (4) @(negedge clk);
    wr = 1;
    repeat (4) @(negedge clk);
    cs = 1; tb_oe = 0;
    @(negedge clk);
  endtask

  task automatic bus_read(output logic [7:0] data);
    aod = 1; cs = 0; rd = 0;
    repeat (SYNC + 1) @(negedge clk);
    data = bus;
    rd = 1;
    repeat (SYNC + 2) @(negedge clk);
    cs = 1;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    bus_write(1'b0, addr);
    bus_write(1'b1, data);
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    bus_write(1'b0, addr);
    bus_read(data);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 4 * T) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (cyc < target) begin n_fail++; $display("FAIL wait_cyc: cyc %0d want >= %0d", cyc, target); end
  endtask

  task automatic test_reset();
    logic [7:0] addrs [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'h00};
    logic [7:0] exps  [10] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] d;
    do_reset();
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_tests++; if (bus !== 8'hff) begin n_fail++; $display("FAIL reset_hiz: got %h want ff", bus); end
    for (int i = 0; i < 10; i++) begin
      read_reg(addrs[i], d);
      n_tests++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL reset_reg_%h: got %h want %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_read_latency();
    logic [7:0] e;
    do_reset();
    write_reg(8'h21, 8'h45);
    aod = 1; cs = 0; rd = 0;
    for (int i = 1; i <= SYNC + 1; i++) begin
      @(negedge clk);
      e = (i == SYNC + 1) ? 8'h45 : 8'hff;
      n_tests++;
      if (bus !== e) begin n_fail++; $display("FAIL rd_lat_%0d: got %h want %h", i, bus, e); end
    end
    rd = 1;
    for (int i = 1; i <= SYNC + 1; i++) begin
      @(negedge clk);
      e = (i == SYNC + 1) ? 8'hff : 8'h45;
      n_tests++;
      if (bus !== e) begin n_fail++; $display("FAIL rd_release_%0d: got %h want %h", i, bus, e); end
    end
    cs = 1;
    @(negedge clk);
  endtask

  task automatic test_rollover();
    logic [7:0] addrs [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    logic [7:0] init  [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};
    logic [7:0] exps  [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) write_reg(addrs[i], init[i]);
    wait_cyc(T + 2);
    for (int i = 0; i < 6; i++) begin
      read_reg(addrs[i], d);
      n_tests++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL rollover_%h: got %h want %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_month_len();
    logic [7:0] addrs [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    logic [7:0] init  [6] = '{8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24};
    logic [7:0] exps  [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h24};
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) write_reg(addrs[i], init[i]);
    wait_cyc(T + 2);
    for (int i = 0; i < 6; i++) begin
      read_reg(addrs[i], d);
      n_tests++;
      if (d !== exps[i]) begin n_fail++; $display("FAIL feb_end_%h: got %h want %h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_bcd_carry();
    logic [7:0] d;
    do_reset();
    write_reg(8'h21, 8'h19);
    write_reg(8'h22, 8'h09);
    wait_cyc(T + 2);
    read_reg(8'h21, d);
    n_tests++; if (d !== 8'h20) begin n_fail++; $display("FAIL bcd_sec: got %h want 20", d); end
    read_reg(8'h22, d);
    n_tests++; if (d !== 8'h09) begin n_fail++; $display("FAIL bcd_min: got %h want 09", d); end
  endtask

  task automatic test_crono();
    logic [7:0] d;
    do_reset();
    write_reg(8'h41, 8'h02);
    write_reg(8'h00, 8'h01);
    wait_cyc(T + 2);
    read_reg(8'h41, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL crono_t1: got %h want 01", d); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL crono_irq_t1: got %b want 0", irq); end
    wait_cyc(2 * T + 2);
    read_reg(8'h41, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL crono_t2: got %h want 00", d); end
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL crono_ctrl_done: got %h want 02", d); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL crono_irq_set: got %b want 1", irq); end
    write_reg(8'h00, 8'h02);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL crono_irq_clr: got %b want 0", irq); end
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL crono_ctrl_clr: got %h want 00", d); end
  endtask

  task automatic test_crono_borrow();
    logic [7:0] d;
    do_reset();
    write_reg(8'h42, 8'h01);
    write_reg(8'h00, 8'h01);
    wait_cyc(T + 2);
    read_reg(8'h41, d);
    n_tests++; if (d !== 8'h59) begin n_fail++; $display("FAIL borrow_sec: got %h want 59", d); end
    read_reg(8'h42, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL borrow_min: got %h want 00", d); end
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL borrow_ctrl: got %h want 01", d); end
  endtask

  task automatic test_crono_zero_enable();
    logic [7:0] d;
    do_reset();
    write_reg(8'h00, 8'h01);
    wait_cyc(T + 2);
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h02) begin n_fail++; $display("FAIL zero_en_ctrl: got %h want 02", d); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL zero_en_irq: got %b want 1", irq); end
  endtask

  task automatic test_tick_collision();
    logic [7:0] d;
    int guard = 0;
    do_reset();
    write_reg(8'h21, 8'h10);
    aod = 1; tb_drv = 8'h30; tb_oe = 1; cs = 0; wr = 0;
    // Releasing Write here lands the commit on the same edge as the first tick
    while (cyc != T - 3 && guard < 2 * T) begin
      @(negedge clk);
      guard++;
    end
    n_tests++; if (cyc != T - 3) begin n_fail++; $display("FAIL collide_align: cyc %0d want %0d", cyc, T - 3); end
    wr = 1;
    repeat (4) @(negedge clk);
    cs = 1; tb_oe = 0;
    @(negedge clk);
    read_reg(8'h21, d);
    n_tests++; if (d !== 8'h31) begin n_fail++; $display("FAIL collide_sec: got %h want 31", d); end
    read_reg(8'h22, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL collide_min: got %h want 00", d); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    do_reset();
    write_reg(8'h21, 8'h12);
    write_reg(8'h7f, 8'h55);
    read_reg(8'h7f, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd: got %h want 00", d); end
    read_reg(8'h21, d);
    n_tests++; if (d !== 8'h12) begin n_fail++; $display("FAIL unmapped_sec: got %h want 12", d); end
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_ctrl: got %h want 00", d); end
    read_reg(8'h24, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL unmapped_day: got %h want 01", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    do_reset();
    write_reg(8'h00, 8'h01);
    wait_cyc(T + 2);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL midrd_irq_pre: got %b want 1", irq); end
    write_reg(8'h24, 8'h15);
    aod = 1; cs = 0; rd = 0;
    repeat (SYNC + 1) @(negedge clk);
    n_tests++; if (bus !== 8'h15) begin n_fail++; $display("FAIL midrd_drive: got %h want 15", bus); end
    rst_n = 0; rd = 1; cs = 1;
    @(negedge clk);
    n_tests++; if (bus !== 8'hff) begin n_fail++; $display("FAIL midrd_hiz: got %h want ff", bus); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrd_irq: got %b want 0", irq); end
    @(negedge clk);
    rst_n = 1;
    bus_read(d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrd_ptr: got %h want 00", d); end
    read_reg(8'h24, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL midrd_day: got %h want 01", d); end
    read_reg(8'h00, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrd_ctrl: got %h want 00", d); end
  endtask

  task automatic test_ignored_strobes();
    logic [7:0] d;
    do_reset();
    write_reg(8'h21, 8'h33);
    aod = 1; tb_drv = 8'h77; tb_oe = 1; cs = 1; wr = 0;
    repeat (4) @(negedge clk);
    wr = 1;
    repeat (4) @(negedge clk);
    tb_oe = 0;
    read_reg(8'h21, d);
    n_tests++; if (d !== 8'h33) begin n_fail++; $display("FAIL cs_high_wr: got %h want 33", d); end
    aod = 1; cs = 1; rd = 0;
    repeat (SYNC + 2) @(negedge clk);
    n_tests++; if (bus !== 8'hff) begin n_fail++; $display("FAIL cs_high_rd: got %h want ff", bus); end
    rd = 1;
    repeat (SYNC + 2) @(negedge clk);
    aod = 1; tb_drv = 8'h66; tb_oe = 1; cs = 0; wr = 0; rd = 0;
    repeat (4) @(negedge clk);
    wr = 1; rd = 1;
    repeat (4) @(negedge clk);
    cs = 1; tb_oe = 0;
    @(negedge clk);
    n_tests++; if (bus !== 8'hff) begin n_fail++; $display("FAIL rdwr_drive: got %h want ff", bus); end
    read_reg(8'h21, d);
    n_tests++; if (d !== 8'h33) begin n_fail++; $display("FAIL rdwr_commit: got %h want 33", d); end
  endtask

  initial begin
    rst_n = 0; cs = 1; rd = 1; wr = 1; aod = 0; tb_oe = 0; tb_drv = 8'h00;
    n_tests = 0; n_fail = 0;
    test_reset();
    test_read_latency();
    test_rollover();
    test_month_len();
    test_bcd_carry();
    test_crono();
    test_crono_borrow();
    test_crono_zero_enable();
    test_tick_collision();
    test_unmapped();
    test_reset_mid_read();
    test_ignored_strobes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_responder.md
RTC_RESPONDER -- requirements
Module: rtc_responder

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 100_000_000: clk cycles per one-second timekeeping tick.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on bus control inputs.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port ChipSelect, input, 1, active-low device select.
REQ-006 The block SHALL have port Read, input, 1, active-low read strobe.
REQ-007 The block SHALL have port Write, input, 1, active-low write strobe.
REQ-008 The block SHALL have port AoD, input, 1, phase select: 0 = address, 1 = data.
REQ-009 The block SHALL have port DATA_ADDRESS, inout, 8, multiplexed address/data bus.
REQ-010 The block SHALL have port crono_irq, output, 1, level copy of control bit1 (crono done).

Function
REQ-011 The block SHALL synchronize ChipSelect, Read, Write and AoD through SYNC_STAGES flops before any use.
REQ-012 While synchronized Write is low with ChipSelect low, the block SHALL register DATA_ADDRESS every cycle; on the synchronized Write rising edge it SHALL commit the last registered value.
REQ-013 On a commit with AoD=0, the block SHALL load the address pointer; with AoD=1, it SHALL write the register at the pointer.
REQ-014 Register map SHALL be: 0x00 control (bit0 crono enable, bit1 crono done, write-1-to-clear), 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 crono sec, 0x42 crono min, 0x43 crono hour; all time values two-digit BCD.
REQ-015 Unmapped addresses SHALL read 0x00; writes to them SHALL be ignored.
REQ-016 On the synchronized Read falling edge with ChipSelect low and AoD=1, the block SHALL snapshot the addressed register and drive it onto DATA_ADDRESS from the next cycle until Read, ChipSelect or AoD deasserts (synchronized); DATA_ADDRESS SHALL be high-Z at all other times.
REQ-017 Read latency SHALL be SYNC_STAGES+1 clk cycles from the Read input falling to bus driven.
REQ-018 A tick counter SHALL pulse once every TICKS_PER_SEC cycles.
REQ-019 On tick, time SHALL increment with BCD carry: sec 59->00, min 59->00, hour 23->00, day per-month limit (31/28/31/30/..., no leap years) ->01, month 12->01, year 99->00.
REQ-020 On tick with crono enable=1, crono SHALL decrement in BCD (sec 00->59 borrow, min 00->59 borrow); on reaching 00:00:00 it SHALL set done=1 and clear enable in the same cycle.
REQ-021 Writing enable=1 with crono already 00:00:00 SHALL set done=1 on the next tick.
REQ-022 A bus commit coinciding with a tick SHALL take priority; the tick SHALL be applied one cycle later.
REQ-023 Non-BCD written values SHALL be stored as written; increment SHALL treat any value >= limit as wrap.
REQ-024 Strobe edges with ChipSelect high SHALL be ignored; simultaneous Read and Write low SHALL perform no commit and no drive.

Reset
REQ-025 On Reset low at a clk edge, all registers SHALL reset: time 00:00:00, day 0x01, month 0x01, year 0x00, crono 0x00, control 0x00, pointer 0x00, tick counter 0.
REQ-026 During and after reset, DATA_ADDRESS SHALL be high-Z and crono_irq 0; a transaction in progress SHALL be abandoned.

Structure
REQ-027 Shared package rtc_pkg SHALL hold register address constants, control bit indices and the month-length table.
REQ-028 One sub-module bcd_pair (two-digit BCD increment/decrement with programmable limit and carry/borrow) SHALL be used for all time and crono fields.

Verification
REQ-029 Address 0x21 write, data 0x45 write, read 0x21 -> bus shows 0x45 after SYNC_STAGES+1 cycles, high-Z after Read rises.
REQ-030 Time 23:59:59, day 0x31, month 0x12, year 0x99; one tick -> 00:00:00, day 0x01, month 0x01, year 0x00.
REQ-031 Crono 00:00:02, enable=1; two ticks -> crono 00:00:00, done=1, enable=0, crono_irq=1; write 0x02 to 0x00 -> crono_irq=0.
REQ-032 Commit to 0x21 on tick cycle with sec=0x10, data 0x30 -> sec 0x31 one cycle later.
REQ-033 Reset low mid-read -> bus high-Z next cycle, all registers at REQ-025 values.
REQ-034 Read of 0x7F -> 0x00; write 0x55 to 0x7F -> no register changes.
